// File: rtl/bsg_chip_pkg.sv
// Chip-level constants and shared types for the gateway link bring-up.
// Link counts, default sequencer timing and the sequencer state encoding.
package bsg_chip_pkg;

    localparam int num_io_links_gp  = 2;
    localparam int num_mem_links_gp = 16;
    localparam int num_links_gp     = num_io_links_gp + num_mem_links_gp;

    localparam int link_token_cycles_gp  = 8;
    localparam int link_settle_cycles_gp = 16;

    typedef enum logic [2:0] {
        e_link_idle  = 3'd0,
        e_link_token = 3'd1,
        e_link_gap   = 3'd2,
        e_link_up    = 3'd3,
        e_link_down  = 3'd4,
        e_link_done  = 3'd5
    } link_seq_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear, used to time each sequencer phase.
// Clear takes priority over the increment.
module bsg_counter_clear_up #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i)
            count_o <= '0;
        else if (up_i)
            count_o <= count_o + width_p'(1);
    end

endmodule

// File: rtl/bsg_gateway_chip_link_reset_seq.sv
// Gateway link reset sequencer: token pulse, upstream, downstream, then
// core reset release for every enabled link; retrain restarts the walk.
module bsg_gateway_chip_link_reset_seq
    import bsg_chip_pkg::*;
#(
    parameter int num_links_p     = num_links_gp,
    parameter int token_cycles_p  = link_token_cycles_gp,
    parameter int settle_cycles_p = link_settle_cycles_gp
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   retrain_i,
    input  logic [num_links_p-1:0] link_en_i,
    output logic [num_links_p-1:0] async_token_reset_o,
    output logic [num_links_p-1:0] up_link_reset_o,
    output logic [num_links_p-1:0] down_link_reset_o,
    output logic [num_links_p-1:0] core_reset_o,
    output logic                   done_o,
    output logic [2:0]             state_o
);

    localparam int max_cycles_lp =
        (token_cycles_p > settle_cycles_p) ? token_cycles_p : settle_cycles_p;
    localparam int cnt_width_lp = $clog2(max_cycles_lp + 1);

    localparam logic [cnt_width_lp-1:0] token_last_lp =
        cnt_width_lp'(token_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] settle_last_lp =
        cnt_width_lp'(settle_cycles_p - 1);

    link_seq_state_e         state_r, state_n;
    logic [num_links_p-1:0]  mask_r, mask_n;
    logic [cnt_width_lp-1:0] cnt;
    logic                    cnt_clear, cnt_up;

    bsg_counter_clear_up #(
        .width_p(cnt_width_lp)
    ) phase_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(cnt_clear),
        .up_i   (cnt_up),
        .count_o(cnt)
    );

    always_comb begin
        state_n = state_r;
        mask_n  = mask_r;
        case (state_r)
            e_link_idle:
                if (start_i) begin
                    state_n = e_link_token;
                    mask_n  = link_en_i;
                end
            e_link_token:
                if (cnt == token_last_lp) state_n = e_link_gap;
            e_link_gap:
                if (cnt == settle_last_lp) state_n = e_link_up;
            e_link_up:
                if (cnt == settle_last_lp) state_n = e_link_down;
            e_link_down:
                if (cnt == settle_last_lp) state_n = e_link_done;
            e_link_done: ;
            default:
                state_n = e_link_idle;
        endcase
        if (retrain_i && state_r != e_link_idle)
            state_n = e_link_idle;
    end

    // Counter restarts from zero on every state entry.
    assign cnt_clear = (state_n != state_r);
    assign cnt_up    = (state_r != e_link_idle) && (state_r != e_link_done);
    assign state_o   = state_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r             <= e_link_idle;
            mask_r              <= '0;
            async_token_reset_o <= '0;
            up_link_reset_o     <= '1;
            down_link_reset_o   <= '1;
            core_reset_o        <= '1;
            done_o              <= 1'b0;
        end else begin
            state_r <= state_n;
            mask_r  <= mask_n;
            async_token_reset_o <=
                (state_n == e_link_token) ? mask_n : '0;
            up_link_reset_o <=
                (state_n inside {e_link_up, e_link_down, e_link_done})
                ? ~mask_n : '1;
            down_link_reset_o <=
                (state_n inside {e_link_down, e_link_done}) ? ~mask_n : '1;
            core_reset_o <= (state_n == e_link_done) ? ~mask_n : '1;
            done_o       <= (state_n == e_link_done);
        end
    end

endmodule

// File: tb/tb_bsg_gateway_chip_link_reset_seq.sv
// Bench for the link reset sequencer: default and minimum-timing instances
// driven together and checked against a start-time based phase model.
module tb_bsg_gateway_chip_link_reset_seq;

    localparam int N = 18;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic start_i = 1'b0;
    logic retrain_i = 1'b0;
    logic [N-1:0] link_en_i = '0;

    logic [N-1:0] tok0, up0, dn0, co0, tok1, up1, dn1, co1;
    logic done0, done1;
    logic [2:0] st0, st1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    bsg_gateway_chip_link_reset_seq dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .retrain_i(retrain_i), .link_en_i(link_en_i),
        .async_token_reset_o(tok0), .up_link_reset_o(up0),
        .down_link_reset_o(dn0), .core_reset_o(co0),
        .done_o(done0), .state_o(st0)
    );

    bsg_gateway_chip_link_reset_seq #(
        .num_links_p(N), .token_cycles_p(1), .settle_cycles_p(1)
    ) dut1 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .retrain_i(retrain_i), .link_en_i(link_en_i),
        .async_token_reset_o(tok1), .up_link_reset_o(up1),
        .down_link_reset_o(dn1), .core_reset_o(co1),
        .done_o(done1), .state_o(st1)
    );

    // Model: a running sequence is described only by its start cycle and mask.
    longint cyc = 0;
    bit run_m[2];
    longint t_m[2];
    logic [N-1:0] mask_m[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset_i) begin
                run_m[i] = 0;
                mask_m[i] = '0;
            end else if (run_m[i]) begin
                if (retrain_i) run_m[i] = 0;
            end else if (start_i) begin
                run_m[i] = 1;
                t_m[i] = cyc;
                mask_m[i] = link_en_i;
            end
        end
        cyc++;
    end

    function automatic int exp_phase(input int i);
        longint k;
        int tt, ss;
        tt = (i == 0) ? 8 : 1;
        ss = (i == 0) ? 16 : 1;
        if (!run_m[i]) return 0;
        k = cyc - t_m[i];
        if (k <= tt) return 1;
        if (k <= tt + ss) return 2;
        if (k <= tt + 2 * ss) return 3;
        if (k <= tt + 3 * ss) return 4;
        return 5;
    endfunction

    task automatic check_inst(input int i, input logic [2:0] st,
                              input logic dn_o, input logic [N-1:0] tk,
                              input logic [N-1:0] up, input logic [N-1:0] dw,
                              input logic [N-1:0] co);
        int ph;
        logic [N-1:0] m, etk, eup, edw, eco;
        ph = exp_phase(i);
        m = mask_m[i];
        etk = (ph == 1) ? m : '0;
        eup = (ph >= 3) ? ~m : '1;
        edw = (ph >= 4) ? ~m : '1;
        eco = (ph == 5) ? ~m : '1;
        checks++;
        if (st !== 3'(ph) || dn_o !== (ph == 5)) begin
            errors++;
            $display("FAIL state inst%0d cyc %0d: got st=%0d done=%b want st=%0d done=%b",
                     i, cyc, st, dn_o, ph, ph == 5);
        end
        checks++;
        if (tk !== etk || up !== eup || dw !== edw || co !== eco) begin
            errors++;
            $display("FAIL links inst%0d cyc %0d: got %h %h %h %h want %h %h %h %h",
                     i, cyc, tk, up, dw, co, etk, eup, edw, eco);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, st0, done0, tok0, up0, dn0, co0);
            check_inst(1, st1, done1, tok1, up1, dn1, co1);
        end
    end

    task automatic lit(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1;
        lit("reset_state", 64'(st0), 64'd0);
        lit("reset_done", 64'(done0), 64'd0);
        lit("reset_token", 64'(tok0), 64'd0);
        lit("reset_up", 64'(up0), 64'h3ffff);
        lit("reset_core", 64'(co0), 64'h3ffff);

        // Full mask, default timing; start cycle is the next posedge.
        reset_i = 0;
        link_en_i = '1;
        start_i = 1;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (j == 1) start_i = 0;
            if (j == 1) lit("token_rise", 64'(tok0), 64'h3ffff);
            if (j == 8) lit("token_hold", 64'(tok0), 64'h3ffff);
            if (j == 9) lit("token_fall", 64'(tok0), 64'd0);
            if (j == 24) lit("up_before", 64'(up0), 64'h3ffff);
            if (j == 25) lit("up_fall", 64'(up0), 64'd0);
            if (j == 40) lit("down_before", 64'(dn0), 64'h3ffff);
            if (j == 41) lit("down_fall", 64'(dn0), 64'd0);
            if (j == 56) lit("done_before", 64'(done0), 64'd0);
            if (j == 57) lit("done_rise", 64'(done0), 64'd1);
            if (j == 57) lit("core_fall", 64'(co0), 64'd0);
            if (j == 4) lit("min_done_before", 64'(done1), 64'd0);
            if (j == 5) lit("min_done_rise", 64'(done1), 64'd1);
        end

        // Partial mask; enables churn in GAP, start drops in DOWN.
        retrain_i = 1;
        @(negedge clk);
        retrain_i = 0;
        lit("retrain_done_idle", 64'(st0), 64'd0);
        link_en_i = 18'h00003;
        start_i = 1;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (j == 20) link_en_i = N'($urandom);
            if (j == 45) start_i = 0;
            if (j == 5) lit("mask_token", 64'(tok0), 64'h00003);
            if (j == 30) lit("mask_up", 64'(up0), 64'h3fffc);
            if (j == 57) lit("mask_done", 64'(done0), 64'd1);
            if (j == 58) lit("mask_core", 64'(co0), 64'h3fffc);
        end

        // Retrain during UP with start still high.
        retrain_i = 1;
        @(negedge clk);
        retrain_i = 0;
        link_en_i = '1;
        start_i = 1;
        repeat (30) @(negedge clk);
        retrain_i = 1;
        @(negedge clk);
        retrain_i = 0;
        lit("retrain_idle", 64'(st0), 64'd0);
        lit("retrain_up", 64'(up0), 64'h3ffff);
        @(negedge clk);
        lit("retrain_token", 64'(st0), 64'd1);
        start_i = 0;
        repeat (55) @(negedge clk);
        lit("retrain_not_done", 64'(done0), 64'd0);
        @(negedge clk);
        lit("retrain_done", 64'(done0), 64'd1);

        // Reset beats retrain and start together.
        reset_i = 1;
        retrain_i = 1;
        start_i = 1;
        @(negedge clk);
        lit("rst_win_state", 64'(st0), 64'd0);
        lit("rst_win_done", 64'(done0), 64'd0);
        lit("rst_win_up", 64'(up0), 64'h3ffff);
        lit("rst_win_token", 64'(tok0), 64'd0);
        reset_i = 0;
        retrain_i = 0;
        start_i = 0;

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start_i = ($urandom_range(0, 3) == 0);
            retrain_i = ($urandom_range(0, 59) == 0);
            reset_i = ($urandom_range(0, 399) == 0);
            link_en_i = N'($urandom);
        end
        @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
